// File: rtl/con_result_wr_if.sv
// Bus between the convolution result producer, the write-back block and the frame SRAM.
interface con_result_wr_if #(
   parameter int unsigned IN_W  = 20,
   parameter int unsigned OUT_W = 16,
   parameter int unsigned AW    = 19
);
   logic             o_en;
   logic [IN_W-1:0]  result;
   logic             clr;
   logic             mem_we;
   logic [AW-1:0]    mem_addr;
   logic [OUT_W-1:0] mem_wdata;
   logic             mem_ready;
   logic             done;
   logic             ovf;
   logic             extra;

   modport master (
      output o_en, result, clr, mem_ready,
      input  mem_we, mem_addr, mem_wdata, done, ovf, extra
   );

   modport slave (
      input  o_en, result, clr, mem_ready,
      output mem_we, mem_addr, mem_wdata, done, ovf, extra
   );
endinterface

// File: rtl/con_result_wr.sv
// Convolution write-back: scale/clamp results, buffer them in a small FIFO and
// write them to a strided frame in SRAM, flagging done once the frame is complete.
module con_result_wr #(
   parameter int unsigned IN_W   = 20,
   parameter int unsigned OUT_W  = 16,
   parameter int unsigned SHIFT  = 0,
   parameter int unsigned COLS   = 510,
   parameter int unsigned ROWS   = 510,
   parameter int unsigned STRIDE = 512,
   parameter int unsigned BASE   = 0,
   parameter int unsigned AW     = 19,
   parameter int unsigned DEPTH  = 4
) (
   input logic              clk,
   input logic              rst,
   con_result_wr_if.slave   bus
);
   localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNTW = $clog2(DEPTH + 1);
   localparam int unsigned COLW = $clog2(COLS + 1);
   localparam int unsigned ROWW = $clog2(ROWS + 1);
   localparam int unsigned CW   = (IN_W > OUT_W) ? IN_W + 1 : OUT_W + 1;
   localparam logic signed [CW-1:0] PMAX = CW'((64'd1 << OUT_W) - 64'd1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                  state_q, state_d;
   logic [OUT_W-1:0]        fifo_q [DEPTH];
   logic [PW-1:0]           rd_q, rd_d, wr_q, wr_d;
   logic [CNTW-1:0]         count_q, count_d;
   logic [COLW-1:0]         col_q, col_d;
   logic [ROWW-1:0]         row_q, row_d;
   logic [AW-1:0]           rowbase_q, rowbase_d, addr_q, addr_d;
   logic                    we_q, we_d;
   logic [OUT_W-1:0]        wdata_q, wdata_d;
   logic                    done_q, done_d, ovf_q, ovf_d, extra_q, extra_d;

   logic signed [IN_W-1:0]  v_s;
   logic signed [CW-1:0]    v_w;
   logic [OUT_W-1:0]        pix_c;
   logic                    popped, last_wr, rd_en, push_req, push_ok;

   // Arithmetic shift then clamp into the unsigned pixel range.
   always_comb begin
      v_s = $signed(bus.result) >>> SHIFT;
      v_w = CW'(v_s);
      if (v_w[CW-1])       pix_c = '0;
      else if (v_w > PMAX) pix_c = '1;
      else                 pix_c = v_w[OUT_W-1:0];
   end

   always_comb begin
      state_d   = state_q;
      rd_d      = rd_q;
      wr_d      = wr_q;
      count_d   = count_q;
      col_d     = col_q;
      row_d     = row_q;
      rowbase_d = rowbase_q;
      addr_d    = addr_q;
      we_d      = we_q;
      wdata_d   = wdata_q;
      done_d    = done_q;
      ovf_d     = ovf_q;
      extra_d   = extra_q;

      popped   = we_q && bus.mem_ready;
      last_wr  = popped && (row_q == ROWW'(ROWS - 1)) && (col_q == COLW'(COLS - 1));
      rd_en    = (count_q != '0) && (!we_q || popped) && !last_wr;
      push_req = bus.o_en && !bus.clr && (state_q != DONE);
      push_ok  = push_req && ((count_q != CNTW'(DEPTH)) || rd_en);

      // mem_addr always holds the address of the write currently presented.
      if (popped) begin
         we_d = 1'b0;
         if (col_q == COLW'(COLS - 1)) begin
            col_d     = '0;
            row_d     = row_q + ROWW'(1);
            rowbase_d = rowbase_q + AW'(STRIDE);
            addr_d    = rowbase_q + AW'(STRIDE);
         end else begin
            col_d  = col_q + COLW'(1);
            addr_d = addr_q + AW'(1);
         end
      end
      if (rd_en) begin
         we_d    = 1'b1;
         wdata_d = fifo_q[rd_q];
         rd_d    = rd_q + PW'(1);
      end
      if (push_ok) wr_d = wr_q + PW'(1);
      count_d = count_q + CNTW'(push_ok) - CNTW'(rd_en);

      if (push_req && !push_ok) ovf_d = 1'b1;
      if (bus.o_en && !bus.clr && (state_q == DONE)) extra_d = 1'b1;

      case (state_q)
         IDLE: if (push_ok) state_d = RUN;
         RUN: begin
            if (last_wr) begin
               state_d = DONE;
               done_d  = 1'b1;
               rd_d    = '0;
               wr_d    = '0;
               count_d = '0;
               we_d    = 1'b0;
            end
         end
         default: ;
      endcase

      if (bus.clr) begin
         state_d   = IDLE;
         rd_d      = '0;
         wr_d      = '0;
         count_d   = '0;
         col_d     = '0;
         row_d     = '0;
         rowbase_d = AW'(BASE);
         addr_d    = AW'(BASE);
         we_d      = 1'b0;
         wdata_d   = '0;
         done_d    = 1'b0;
         ovf_d     = 1'b0;
         extra_d   = 1'b0;
      end
   end

   // FIFO storage carries no reset; validity is tracked by count/pointers.
   always_ff @(posedge clk) begin
      if (push_ok) fifo_q[wr_q] <= pix_c;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         rd_q      <= '0;
         wr_q      <= '0;
         count_q   <= '0;
         col_q     <= '0;
         row_q     <= '0;
         rowbase_q <= AW'(BASE);
         addr_q    <= AW'(BASE);
         we_q      <= 1'b0;
         wdata_q   <= '0;
         done_q    <= 1'b0;
         ovf_q     <= 1'b0;
         extra_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         rd_q      <= rd_d;
         wr_q      <= wr_d;
         count_q   <= count_d;
         col_q     <= col_d;
         row_q     <= row_d;
         rowbase_q <= rowbase_d;
         addr_q    <= addr_d;
         we_q      <= we_d;
         wdata_q   <= wdata_d;
         done_q    <= done_d;
         ovf_q     <= ovf_d;
         extra_q   <= extra_d;
      end
   end

   assign bus.mem_we    = we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.done      = done_q;
   assign bus.ovf       = ovf_q;
   assign bus.extra     = extra_q;
endmodule
